// File: rtl/ldo_pkg.sv
// Shared definitions for the LDO trim controller: FSM states, default sizes
// and the power-on trim index table.
package ldo_pkg;

  localparam int N_LDO_DEF  = 3;
  localparam int TRIM_W_DEF = 16;
  localparam int IDX_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT,
    ST_DONE
  } ldo_state_t;

  // Power-on trim index per LDO; unlisted instances start at the bottom code.
  function automatic logic [IDX_W-1:0] rst_idx(input int k);
    case (k)
      0:       return 4'd6;
      1:       return 4'd8;
      2:       return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ldo_sync2.sv
// Two-flop synchronizer for asynchronous comparator inputs.
module ldo_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/ldo_trim_ctrl.sv
// Auto-calibration of several LDO trim codes: walks each LDO's one-hot trim
// until its output sits inside the comparator window, flagging failures.
module ldo_trim_ctrl
  import ldo_pkg::*;
#(
  parameter int N_LDO      = N_LDO_DEF,
  parameter int TRIM_W     = TRIM_W_DEF,
  parameter int SETTLE_CYC = 64,
  parameter int MAX_STEPS  = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n,
  input  logic                      start_i,
  input  logic                      cfg_we_i,
  input  logic [1:0]                cfg_sel_i,
  input  logic [IDX_W-1:0]          cfg_idx_i,
  input  logic [N_LDO-1:0]          cmp_hi_i,
  input  logic [N_LDO-1:0]          cmp_lo_i,
  output logic [N_LDO*TRIM_W-1:0]   trim_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [N_LDO-1:0]          cal_err_o
);

  localparam int PTR_W  = (N_LDO > 1) ? $clog2(N_LDO) : 1;
  localparam int CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(N_LDO - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX    = IDX_W'(TRIM_W - 1);

  ldo_state_t         state_reg, state_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [STEP_W-1:0]  step_reg, step_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [N_LDO-1:0]   err_reg, err_next;
  logic [IDX_W-1:0]   idx_reg [N_LDO];
  logic [IDX_W-1:0]   idx_next [N_LDO];

  logic [N_LDO-1:0]   cmp_hi_s;
  logic [N_LDO-1:0]   cmp_lo_s;
  logic               hi_cur;
  logic               lo_cur;
  logic [IDX_W-1:0]   idx_cur;

  ldo_sync2 #(.W(N_LDO)) u_sync_hi (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .d     (cmp_hi_i),
    .q     (cmp_hi_s)
  );

  ldo_sync2 #(.W(N_LDO)) u_sync_lo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .d     (cmp_lo_i),
    .q     (cmp_lo_s)
  );

  assign hi_cur  = cmp_hi_s[ptr_reg];
  assign lo_cur  = cmp_lo_s[ptr_reg];
  assign idx_cur = idx_reg[ptr_reg];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      step_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= '0;
      for (int k = 0; k < N_LDO; k++) begin
        idx_reg[k] <= rst_idx(k);
      end
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      step_reg  <= step_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      for (int k = 0; k < N_LDO; k++) begin
        idx_reg[k] <= idx_next[k];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    step_next  = step_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    for (int k = 0; k < N_LDO; k++) begin
      idx_next[k] = idx_reg[k];
    end

    case (state_reg)
      ST_IDLE: begin
        // A write in the start cycle lands first, so calibration begins from it.
        for (int k = 0; k < N_LDO; k++) begin
          if (cfg_we_i && (int'(cfg_sel_i) == k)) begin
            idx_next[k] = cfg_idx_i;
          end
        end
        if (start_i) begin
          err_next   = '0;
          ptr_next   = '0;
          step_next  = '0;
          cnt_next   = CNT_RELOAD;
          state_next = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_reg == '0) begin
          state_next = ST_SAMPLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (hi_cur == lo_cur) begin
          state_next = ST_NEXT;
        end else if ((hi_cur && (idx_cur == '0)) ||
                     (lo_cur && (idx_cur == IDX_MAX)) ||
                     (step_reg >= STEP_LIMIT)) begin
          err_next[ptr_reg] = 1'b1;
          state_next        = ST_NEXT;
        end else begin
          idx_next[ptr_reg] = hi_cur ? (idx_cur - 1'b1) : (idx_cur + 1'b1);
          step_next         = step_reg + 1'b1;
          cnt_next          = CNT_RELOAD;
          state_next        = ST_SETTLE;
        end
      end

      ST_NEXT: begin
        if (ptr_reg == PTR_LAST) begin
          state_next = ST_DONE;
        end else begin
          ptr_next   = ptr_reg + 1'b1;
          step_next  = '0;
          cnt_next   = CNT_RELOAD;
          state_next = ST_SETTLE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy_o    = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE) ||
                     (state_reg == ST_NEXT);
  assign done_o    = (state_reg == ST_DONE);
  assign cal_err_o = err_reg;

  generate
    for (genvar gi = 0; gi < N_LDO; gi++) begin : g_trim
      assign trim_o[gi*TRIM_W +: TRIM_W] = {{(TRIM_W-1){1'b0}}, 1'b1} << idx_reg[gi];
    end
  endgenerate

endmodule

// File: doc/ldo_trim_ctrl.md
LDO_TRIM_CTRL -- requirements
Module: ldo_trim_ctrl

Interface
REQ-001 Parameter N_LDO, default 3: number of fullldom instances driven.
REQ-002 Parameter TRIM_W, default 16: trim bus width per LDO (one-hot).
REQ-003 Parameter SETTLE_CYC, default 64: clock cycles waited after each trim change before sampling comparators.
REQ-004 Parameter MAX_STEPS, default 16: trim moves allowed per LDO before it is declared failed.
REQ-005 wb_clk_i  in  1  single clock; all state on its rising edge.
REQ-006 wb_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start_i  in  1  one-cycle pulse; launches auto-calibration of all LDOs.
REQ-008 cfg_we_i  in  1  manual trim-index write strobe.
REQ-009 cfg_sel_i  in  2  LDO selected by cfg_we_i.
REQ-010 cfg_idx_i  in  4  trim index (0..15) written.
REQ-011 cmp_hi_i  in  N_LDO  async comparator per LDO; 1 = output above window.
REQ-012 cmp_lo_i  in  N_LDO  async comparator per LDO; 1 = output below window.
REQ-013 trim_o  out  N_LDO*TRIM_W  one-hot trim codes; LDO k occupies bits [k*TRIM_W +: TRIM_W].
REQ-014 busy_o  out  1  high while calibration runs.
REQ-015 done_o  out  1  one-cycle pulse when calibration ends.
REQ-016 cal_err_o  out  N_LDO  sticky per-LDO failure flags from the last calibration.

Function
REQ-017 Each LDO shall hold a 4-bit trim index; trim_o slice k shall equal 1 << idx[k], exactly one bit set in every cycle.
REQ-018 cmp_hi_i and cmp_lo_i shall pass through a 2-flop synchronizer before use; sample latency is 2 cycles.
REQ-019 FSM states: IDLE, SETTLE, SAMPLE, NEXT, DONE.
REQ-020 IDLE: start_i=1 -> clear cal_err_o, ldo_ptr=0, step_cnt=0, settle counter=SETTLE_CYC-1, go to SETTLE; busy_o=1 from the next cycle.
REQ-021 SETTLE: decrement the counter each cycle; at 0 go to SAMPLE.
REQ-022 SAMPLE, with hi=cmp_hi_s[ptr] and lo=cmp_lo_s[ptr]: hi&!lo -> idx-1; !hi&lo -> idx+1; hi==lo -> locked, go to NEXT.
REQ-023 After a move: step_cnt+1, reload the settle counter, go to SETTLE.
REQ-024 Boundary: decrement request at idx=0, increment request at idx=15, or step_cnt reaching MAX_STEPS -> set cal_err_o[ptr], leave idx unchanged, go to NEXT.
REQ-025 NEXT: ptr==N_LDO-1 -> DONE; otherwise ptr+1, step_cnt=0, reload the counter, go to SETTLE.
REQ-026 DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE.
REQ-027 start_i while busy_o=1 shall be ignored.
REQ-028 cfg_we_i in IDLE shall set idx[cfg_sel_i]=cfg_idx_i the next cycle; it shall be ignored while busy or when cfg_sel_i>=N_LDO.
REQ-029 cfg_we_i and start_i in the same IDLE cycle: apply the write first, then calibrate starting from the written index.

Reset
REQ-030 wb_rst_n=0 shall asynchronously force: state IDLE; idx = {0:6, 1:8, 2:10}, so trim_o[15:0]=0x0040, [31:16]=0x0100, [47:32]=0x0400; busy_o=0; done_o=0; cal_err_o=0; counters and synchronizers 0.
REQ-031 Reset asserted mid-calibration shall abort at once to the reset values, with no done_o pulse.

Structure
REQ-032 Shared package ldo_pkg shall hold the FSM state enum, the TRIM_W and N_LDO defaults, and the reset index table.
REQ-033 One sub-module, ldo_sync2 (2-flop synchronizer, width-parameterised), shall be instantiated for cmp_hi_i and cmp_lo_i.

Verification
REQ-034 Release reset -> trim_o = 0x0400_0100_0040, busy_o=0, cal_err_o=0.
REQ-035 start_i, all comparators 0 -> busy_o for 3*(SETTLE_CYC+1)+few cycles, one done_o pulse, trim unchanged, cal_err_o=0.
REQ-036 LDO0 cmp_lo held 1 for 3 samples, then 0 -> idx0 6->9 (trim bits 0x0200), no error.
REQ-037 Write idx1=0, then cmp_hi_i[1]=1 during calibration -> cal_err_o[1]=1, trim_o[31:16]=0x0001.
REQ-038 Assert reset mid-SETTLE of LDO2 -> reset values immediately, no done_o pulse.
REQ-039 Every cycle of every test: each trim_o slice is one-hot (assertion).
